// File: rtl/alu_arb_pkg.sv
// Shared opcode, state and helper definitions for the ALU arbiter.
// Illegal-opcode trapping is enabled by defining ALU_ARB_ILLEGAL_OP_EN.
package alu_arb_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    localparam logic [3:0] ALU_OP_LAST = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } arb_state_t;

    // Opcodes above ALU_OP_LAST have no ALU meaning.
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= ALU_OP_LAST);
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request strictly after i_ptr, with wrap.
module rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;

    // Walk ptr+1 .. ptr+NUM_REQ; the first hit wins, so ptr itself is checked last.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!o_any && i_req[w_cand]) begin
                o_any          = 1'b1;
                o_idx          = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU among NUM_REQ requesters.
// Define ALU_ARB_ILLEGAL_OP_EN to trap illegal opcodes and add the rsp_err output.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned XLEN    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [4*NUM_REQ-1:0]    req_op,
    input  logic [XLEN*NUM_REQ-1:0] req_a,
    input  logic [XLEN*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [XLEN-1:0]         rsp_data,
    output logic [3:0]              alu_op,
    output logic [XLEN-1:0]         alu_a,
    output logic [XLEN-1:0]         alu_b,
    input  logic [XLEN-1:0]         alu_res
`ifdef ALU_ARB_ILLEGAL_OP_EN
    ,
    output logic                    rsp_err
`endif
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_gnt;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [XLEN-1:0]    r_rsp_data;
    logic [3:0]         r_alu_op;
    logic [XLEN-1:0]    r_alu_a;
    logic [XLEN-1:0]    r_alu_b;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic               r_illegal;
    logic               r_rsp_err;
`endif

    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_idx;
    logic               w_any;
    logic               w_accept;
    logic [3:0]         w_op;
    logic [XLEN-1:0]    w_a;
    logic [XLEN-1:0]    w_b;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_accept = (r_state == ST_IDLE) && w_any;

    // Handshake must answer in the request cycle; held low while reset is asserted.
    assign req_ready = (w_accept && rst_n) ? w_grant : '0;

    // Select the winner's opcode and operands.
    always_comb begin
        w_op = '0;
        w_a  = '0;
        w_b  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_idx == IDX_W'(i)) begin
                w_op = req_op[4*i +: 4];
                w_a  = req_a[XLEN*i +: XLEN];
                w_b  = req_b[XLEN*i +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= IDX_W'(NUM_REQ - 1);
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_alu_op    <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
            r_illegal   <= 1'b0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_gnt   <= w_idx;
                        r_ptr   <= w_idx;
                        r_state <= ST_EXEC;
`ifdef ALU_ARB_ILLEGAL_OP_EN
                        // Illegal opcodes never reach the ALU pins.
                        r_illegal <= !op_is_legal(w_op);
                        if (op_is_legal(w_op)) begin
                            r_alu_op <= w_op;
                            r_alu_a  <= w_a;
                            r_alu_b  <= w_b;
                        end
`else
                        r_alu_op <= w_op;
                        r_alu_a  <= w_a;
                        r_alu_b  <= w_b;
`endif
                    end
                end
                ST_EXEC: begin
`ifdef ALU_ARB_ILLEGAL_OP_EN
                    r_rsp_data <= r_illegal ? '0 : alu_res;
                    r_rsp_err  <= r_illegal;
`else
                    r_rsp_data <= alu_res;
`endif
                    r_rsp_valid <= NUM_REQ'(1) << r_gnt;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready[r_gnt]) begin
                        r_rsp_valid <= '0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign alu_op    = r_alu_op;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    assign rsp_err   = r_rsp_err;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural 32-bit ALU attached.
module tb_alu_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned XL = 32;

    logic             clk;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [4*NR-1:0]  req_op;
    logic [XL*NR-1:0] req_a;
    logic [XL*NR-1:0] req_b;
    logic [NR-1:0]    rsp_valid;
    logic [NR-1:0]    rsp_ready;
    logic [XL-1:0]    rsp_data;
    logic [3:0]       alu_op;
    logic [XL-1:0]    alu_a;
    logic [XL-1:0]    alu_b;
    logic [XL-1:0]    alu_res;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic             rsp_err;
`endif

    int n_cmp;
    int n_err;

    alu_arbiter #(.NUM_REQ(NR), .XLEN(XL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_res   (alu_res)
`ifdef ALU_ARB_ILLEGAL_OP_EN
        ,
        .rsp_err   (rsp_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The shared ALU the arbiter drives; illegal codes return a marker value.
    always_comb begin
        case (alu_op)
            4'b0000: alu_res = alu_a + alu_b;
            4'b0001: alu_res = alu_a - alu_b;
            4'b0010: alu_res = {31'b0, $signed(alu_a) < $signed(alu_b)};
            4'b0011: alu_res = {31'b0, alu_a < alu_b};
            4'b0100: alu_res = alu_a << alu_b[4:0];
            4'b0101: alu_res = alu_a >> alu_b[4:0];
            4'b0110: alu_res = 32'($signed(alu_a) >>> alu_b[4:0]);
            4'b0111: alu_res = alu_a ^ alu_b;
            4'b1000: alu_res = alu_a | alu_b;
            4'b1001: alu_res = alu_a & alu_b;
            default: alu_res = 32'hDEAD_BEEF;
        endcase
    end

    task automatic set_req(input int i, input logic [3:0] op, input logic [XL-1:0] a, input logic [XL-1:0] b);
        req_op[4*i +: 4]  = op;
        req_a[XL*i +: XL] = a;
        req_b[XL*i +: XL] = b;
        req_valid[i]      = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; rsp_ready = '0; req_op = '0; req_a = '0; req_b = '0;
        repeat (2) @(negedge clk);
        req_valid = 4'b1111;
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid); end
        n_cmp++; if (rsp_data !== 32'h0) begin n_err++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
        n_cmp++; if ({alu_op, alu_a, alu_b} !== 68'h0) begin n_err++; $display("FAIL reset_alu got %h %h %h want 0", alu_op, alu_a, alu_b); end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        set_req(2, 4'b0000, 32'd5, 32'd7);
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready got %b want 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_cmp++; if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000) begin n_err++; $display("FAIL single_exec got rdy %b vld %b want 0/0", req_ready, rsp_valid); end
        n_cmp++; if (alu_op !== 4'b0000 || alu_a !== 32'd5 || alu_b !== 32'd7) begin n_err++; $display("FAIL single_alu got %b %h %h want 0000 5 7", alu_op, alu_a, alu_b); end
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 4'b0100 || rsp_data !== 32'd12) begin n_err++; $display("FAIL single_rsp got %b %h want 0100 0000000c", rsp_valid, rsp_data); end
        rsp_ready = 4'b1111;
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL single_done got %b want 0000", rsp_valid); end
        rsp_ready = '0;
    endtask

    task automatic test_ops();
        logic [3:0]    t_op  [10];
        logic [XL-1:0] t_a   [10];
        logic [XL-1:0] t_b   [10];
        logic [XL-1:0] t_exp [10];
        t_op = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1001};
        t_a  = '{32'hFFFFFFFF, 32'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'h80000000, 32'h80000000, 32'hF0F0F0F0, 32'h000000F0, 32'hF0F0F0F0};
        t_b  = '{32'd1, 32'd3, 32'd1, 32'd1, 32'd31, 32'd4, 32'd4, 32'hFF00FF00, 32'h00000F00, 32'hFF00FF00};
        t_exp = '{32'h0, 32'd7, 32'd1, 32'd0, 32'h80000000, 32'h08000000, 32'hF8000000, 32'h0FF00FF0, 32'h00000FF0, 32'hF000F000};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            rsp_ready = '0;
            set_req(0, t_op[k], t_a[k], t_b[k]);
            #1;
            n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL ops_ready[%0d] got %b want 0001", k, req_ready); end
            @(negedge clk);
            req_valid = '0;
            @(negedge clk);
            n_cmp++; if (rsp_valid !== 4'b0001 || rsp_data !== t_exp[k]) begin n_err++; $display("FAIL ops_rsp[%0d] got %b %h want 0001 %h", k, rsp_valid, rsp_data, t_exp[k]); end
`ifdef ALU_ARB_ILLEGAL_OP_EN
            n_cmp++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL ops_err[%0d] got %b want 0", k, rsp_err); end
`endif
            rsp_ready = 4'b0001;
        end
        @(negedge clk);
        rsp_ready = '0;
    endtask

    task automatic test_contention();
        int            grants;
        int            last_c;
        logic [NR-1:0] exp_rsp;
        logic [XL-1:0] exp_data;
        rst_n = 1'b0;
        req_valid = '0;
        for (int i = 0; i < 4; i++) set_req(i, 4'b0000, 32'(10 * i), 32'd1);
        rsp_ready = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        grants = 0; last_c = 0; exp_rsp = '0; exp_data = '0;
        for (int c = 0; c < 40 && grants < 5; c++) begin
            if (req_ready !== 4'b0000) begin
                n_cmp++; if (req_ready !== (4'b0001 << (grants % 4))) begin n_err++; $display("FAIL rr_grant[%0d] got %b want %b", grants, req_ready, 4'b0001 << (grants % 4)); end
                if (grants > 0) begin
                    n_cmp++; if (c - last_c != 3) begin n_err++; $display("FAIL rr_spacing[%0d] got %0d want 3", grants, c - last_c); end
                end
                exp_rsp  = 4'b0001 << (grants % 4);
                exp_data = 32'(10 * (grants % 4) + 1);
                last_c   = c;
                grants++;
            end
            if (rsp_valid !== 4'b0000) begin
                n_cmp++; if (rsp_valid !== exp_rsp || rsp_data !== exp_data) begin n_err++; $display("FAIL rr_rsp got %b %h want %b %h", rsp_valid, rsp_data, exp_rsp, exp_data); end
            end
            @(negedge clk);
            #1;
        end
        n_cmp++; if (grants != 5) begin n_err++; $display("FAIL rr_count got %0d want 5", grants); end
        req_valid = '0;
        repeat (4) @(negedge clk);
        rsp_ready = '0;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        set_req(1, 4'b0001, 32'd3, 32'd5);
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_ready got %b want 0010", req_ready); end
        @(negedge clk);
        req_valid = 4'b1101;
        rsp_ready = 4'b1101;
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            #1;
            n_cmp++; if (rsp_valid !== 4'b0010 || rsp_data !== 32'hFFFFFFFE || req_ready !== 4'b0000) begin
                n_err++; $display("FAIL bp_stall[%0d] got vld %b data %h rdy %b want 0010 fffffffe 0000", c, rsp_valid, rsp_data, req_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 4'b1111;
        @(negedge clk);
        #1;
        n_cmp++; if (rsp_valid !== 4'b0000 || req_ready !== 4'b0100) begin n_err++; $display("FAIL bp_release got vld %b rdy %b want 0000 0100", rsp_valid, req_ready); end
        req_valid = '0;
        rsp_ready = '0;
    endtask

    task automatic test_reset_exec();
        @(negedge clk);
        set_req(3, 4'b0000, 32'd1, 32'd1);
        #1;
        n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL rx_ready got %b want 1000", req_ready); end
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 4'b1111;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (alu_a !== 32'h0 || alu_b !== 32'h0) begin n_err++; $display("FAIL rx_async got %h %h want 0 0", alu_a, alu_b); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL rx_norsp[%0d] got %b want 0000", c, rsp_valid); end
        end
        rst_n = 1'b1;
        req_valid = 4'b1111;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rx_first got %b want 0001", req_ready); end
        req_valid = '0;
        rsp_ready = '0;
    endtask

    task automatic test_illegal();
        @(negedge clk);
        set_req(0, 4'b1100, 32'd9, 32'd9);
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL ill_ready got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
        n_cmp++; if (alu_a !== 32'h0 || alu_op !== 4'b0000) begin n_err++; $display("FAIL ill_alu_hold got %b %h want 0000 0", alu_op, alu_a); end
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 4'b0001 || rsp_data !== 32'h0 || rsp_err !== 1'b1) begin n_err++; $display("FAIL ill_rsp got %b %h err %b want 0001 0 1", rsp_valid, rsp_data, rsp_err); end
`else
        n_cmp++; if (alu_op !== 4'b1100 || alu_a !== 32'd9) begin n_err++; $display("FAIL ill_alu_fwd got %b %h want 1100 9", alu_op, alu_a); end
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 4'b0001 || rsp_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL ill_rsp got %b %h want 0001 deadbeef", rsp_valid, rsp_data); end
`endif
        rsp_ready = 4'b0001;
        @(negedge clk);
        rsp_ready = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_ops();
        test_contention();
        test_backpressure();
        test_reset_exec();
        test_illegal();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
